// File: rtl/arm7tdmi_pkg.sv
// Types and defaults shared by the ARM7TDMI front-end blocks.
// fetch_pkt_t is the unit of transfer between the fetch unit, the prefetch queue and decode.
package arm7tdmi_pkg;

    localparam int PQ_DEPTH_DEFAULT = 3;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        thumb;
        logic        abort;
    } fetch_pkt_t;

endpackage

// File: rtl/arm7tdmi_prefetch_queue.sv
// In-order instruction queue between fetch and decode.
// Absorbs decode backpressure, stalls fetch when full, and empties in one cycle on flush.
module arm7tdmi_prefetch_queue
    import arm7tdmi_pkg::*;
#(
    parameter int DEPTH = PQ_DEPTH_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [31:0]                in_instr,
    input  logic [31:0]                in_pc,
    input  logic                       in_thumb,
    input  logic                       in_abort,
    output logic                       in_stall,
    output logic                       out_valid,
    output logic [31:0]                out_instr,
    output logic [31:0]                out_pc,
    output logic                       out_thumb,
    output logic                       out_abort,
    input  logic                       out_ready,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Explicit wrap so DEPTH does not have to be a power of two.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    fetch_pkt_t       mem_q [DEPTH];
    fetch_pkt_t       mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic       push;
    logic       pop;
    fetch_pkt_t in_pkt;
    fetch_pkt_t head;

    // Status comes from registered occupancy only, so out_ready never reaches in_stall.
    assign in_stall  = (count_q == FULL_CNT);
    assign out_valid = (count_q != '0);
    assign push      = in_valid & ~in_stall & ~flush;
    assign pop       = out_valid & out_ready & ~flush;
    assign count     = count_q;

    assign in_pkt = '{instr: in_instr, pc: in_pc, thumb: in_thumb, abort: in_abort};
    assign head   = mem_q[rd_ptr_q];

    assign out_instr = head.instr;
    assign out_pc    = head.pc;
    assign out_thumb = head.thumb;
    assign out_abort = head.abort;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            // Payload is left in place; only the pointers and occupancy define validity.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = in_pkt;
                wr_ptr_d        = next_ptr(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = next_ptr(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        count_q <= FULL_CNT);
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(pop && count_q == '0));
    a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && count_q == FULL_CNT));

endmodule
